// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard/forwarding bundle: destination and source info in, forwarding
// selects, stall and per-stage destinations out.
interface hazard_forward_unit_if;
  logic [4:0] d_wr;
  logic       d_reg_write;
  logic       d_load;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [4:0] e_wr;
  logic [4:0] m_wr;
  logic [4:0] w_wr;
  logic       w_reg_write;

  modport master (
    output d_wr, d_reg_write, d_load, d_rs, d_rt, d_use_rs, d_use_rt, flush,
    input  stall, fwd_a, fwd_b, e_wr, m_wr, w_wr, w_reg_write
  );

  modport slave (
    input  d_wr, d_reg_write, d_load, d_rs, d_rt, d_use_rs, d_use_rt, flush,
    output stall, fwd_a, fwd_b, e_wr, m_wr, w_wr, w_reg_write
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Carries destination register info through EX/MEM/WB and derives operand
// forwarding selects plus the one-cycle load-use stall for the ID stage.
module hazard_forward_unit (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave bus
);

  logic [4:0] e_wr_reg, m_wr_reg, w_wr_reg;
  logic       e_reg_write_reg, m_reg_write_reg, w_reg_write_reg;
  logic       e_load_reg;

  logic [4:0] e_wr_next;
  logic       e_reg_write_next;
  logic       e_load_next;

  logic       e_live, m_live, w_live;
  logic       bubble;

  // $0 is hard-wired zero, so it can never be a forwarding source.
  assign e_live = e_reg_write_reg && (e_wr_reg != 5'd0);
  assign m_live = m_reg_write_reg && (m_wr_reg != 5'd0);
  assign w_live = w_reg_write_reg && (w_wr_reg != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0] src;
      logic       use_src;
      logic       hit_e;
      logic       hit_m;
      logic       hit_w;
      logic [1:0] sel;

      assign src     = (gi == 0) ? bus.d_rs : bus.d_rt;
      assign use_src = (gi == 0) ? bus.d_use_rs : bus.d_use_rt;
      assign hit_e   = use_src && e_live && (e_wr_reg == src);
      assign hit_m   = use_src && m_live && (m_wr_reg == src);
      assign hit_w   = use_src && w_live && (w_wr_reg == src);

      // A load in E has no result yet; skip it and let older stages match.
      assign sel = (hit_e && !e_load_reg) ? 2'b01 :
                   hit_m                  ? 2'b10 :
                   hit_w                  ? 2'b11 : 2'b00;
    end
  endgenerate

  assign bus.stall = e_load_reg && (g_fwd[0].hit_e || g_fwd[1].hit_e);
  assign bus.fwd_a = g_fwd[0].sel;
  assign bus.fwd_b = g_fwd[1].sel;
  assign bubble    = bus.stall || bus.flush;

  always_comb begin
    e_wr_next        = bus.d_wr;
    e_reg_write_next = bus.d_reg_write;
    e_load_next      = bus.d_load;
    if (bubble) begin
      e_wr_next        = 5'd0;
      e_reg_write_next = 1'b0;
      e_load_next      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_wr_reg        <= 5'd0;
      e_reg_write_reg <= 1'b0;
      e_load_reg      <= 1'b0;
      m_wr_reg        <= 5'd0;
      m_reg_write_reg <= 1'b0;
      w_wr_reg        <= 5'd0;
      w_reg_write_reg <= 1'b0;
    end else begin
      e_wr_reg        <= e_wr_next;
      e_reg_write_reg <= e_reg_write_next;
      e_load_reg      <= e_load_next;
      m_wr_reg        <= e_wr_reg;
      m_reg_write_reg <= e_reg_write_reg;
      w_wr_reg        <= m_wr_reg;
      w_reg_write_reg <= m_reg_write_reg;
    end
  end

  assign bus.e_wr        = e_wr_reg;
  assign bus.m_wr        = m_wr_reg;
  assign bus.w_wr        = w_wr_reg;
  // Writes to $0 are suppressed at the register file port.
  assign bus.w_reg_write = w_reg_write_reg && (w_wr_reg != 5'd0);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_forward_unit;

  logic clk;
  logic rst;

  hazard_forward_unit_if bus ();

  hazard_forward_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int         idx;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] ew;
    logic [4:0] mw;
    logic [4:0] ww;
    logic       wrw;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_idx  = 0;
  bit   done     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void cmp(string name, int idx, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL vec%0d %s got=%0d want=%0d", idx, name, got, want);
    end
  endfunction

  function automatic void cmp_all(exp_t e);
    cmp("stall",       e.idx, int'(bus.stall),       int'(e.stall));
    cmp("fwd_a",       e.idx, int'(bus.fwd_a),       int'(e.fa));
    cmp("fwd_b",       e.idx, int'(bus.fwd_b),       int'(e.fb));
    cmp("e_wr",        e.idx, int'(bus.e_wr),        int'(e.ew));
    cmp("m_wr",        e.idx, int'(bus.m_wr),        int'(e.mw));
    cmp("w_wr",        e.idx, int'(bus.w_wr),        int'(e.ww));
    cmp("w_reg_write", e.idx, int'(bus.w_reg_write), int'(e.wrw));
  endfunction

  // Monitor: combinational outputs are settled by the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp_all(e);
      $display("vec%0d stall=%0d fwd_a=%0d fwd_b=%0d e=%0d m=%0d w=%0d wrw=%0d",
               e.idx, bus.stall, bus.fwd_a, bus.fwd_b, bus.e_wr, bus.m_wr,
               bus.w_wr, bus.w_reg_write);
    end
  end

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] wr, input logic rw,
                       input logic ld, input logic fl);
    bus.d_rs        = rs;
    bus.d_use_rs    = urs;
    bus.d_rt        = rt;
    bus.d_use_rt    = urt;
    bus.d_wr        = wr;
    bus.d_reg_write = rw;
    bus.d_load      = ld;
    bus.flush       = fl;
  endtask

  // One ID-stage cycle: drive just after the rising edge, queue the expectation.
  task automatic step(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] wr, input logic rw,
                      input logic ld, input logic fl,
                      input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [4:0] ew, input logic [4:0] mw, input logic [4:0] ww,
                      input logic wrw);
    exp_t e;
    @(posedge clk);
    #1;
    drive(rs, urs, rt, urt, wr, rw, ld, fl);
    e.idx = vec_idx; e.stall = st; e.fa = fa; e.fb = fb;
    e.ew = ew; e.mw = mw; e.ww = ww; e.wrw = wrw;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  initial begin
    exp_t z;
    z.idx = -1; z.stall = 0; z.fa = 0; z.fb = 0; z.ew = 0; z.mw = 0; z.ww = 0; z.wrw = 0;
    rst = 1'b1;
    drive(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    cmp_all(z);                       // outputs held at zero during reset
    rst = 1'b0;

    //    rs   urs rt  urt wr  rw ld fl | st fa    fb    e   m   w   wrw
    step(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 0);  // 0 reset state
    step(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0,  0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 0);  // 1 add $3
    step(5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0,  0, 2'd1, 2'd1, 5'd3, 5'd0, 5'd0, 0);  // 2 add $4,$3,$3
    step(5'd3, 1, 5'd0, 1, 5'd10,1, 0, 0,  0, 2'd2, 2'd0, 5'd4, 5'd3, 5'd0, 0);  // 3 $3 from M
    step(5'd0, 1, 5'd3, 1, 5'd11,1, 0, 0,  0, 2'd0, 2'd3, 5'd10,5'd4, 5'd3, 1);  // 4 $3 from W
    step(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0,  0, 2'd0, 2'd0, 5'd11,5'd10,5'd4, 1);  // 5 lw $5
    step(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0,  1, 2'd0, 2'd0, 5'd5, 5'd11,5'd10,1);  // 6 load-use stall
    step(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0,  0, 2'd2, 2'd0, 5'd0, 5'd5, 5'd11,1);  // 7 retry, bubble in E
    step(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0,  0, 2'd0, 2'd0, 5'd6, 5'd0, 5'd5, 1);  // 8 add $7
    step(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0,  0, 2'd0, 2'd0, 5'd7, 5'd6, 5'd0, 0);  // 9 add $7 again
    step(5'd7, 1, 5'd6, 1, 5'd12,1, 0, 0,  0, 2'd1, 2'd3, 5'd7, 5'd7, 5'd6, 1);  // 10 E beats M
    step(5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0,  0, 2'd0, 2'd0, 5'd12,5'd7, 5'd7, 1);  // 11 write $0
    step(5'd0, 1, 5'd0, 0, 5'd8, 1, 1, 0,  0, 2'd0, 2'd0, 5'd0, 5'd12,5'd7, 1);  // 12 read $0, E=$0
    step(5'd1, 1, 5'd8, 0, 5'd0, 0, 0, 0,  0, 2'd0, 2'd0, 5'd8, 5'd0, 5'd12,1);  // 13 lw $8, rt unused
    step(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1,  0, 2'd0, 2'd0, 5'd0, 5'd8, 5'd0, 0);  // 14 flush $9, W=$0
    step(5'd0, 0, 5'd0, 0, 5'd13,1, 1, 0,  0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd8, 1);  // 15 lw $13
    step(5'd13,1, 5'd0, 0, 5'd14,1, 0, 1,  1, 2'd0, 2'd0, 5'd13,5'd0, 5'd0, 0);  // 16 flush + load-use
    step(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 2'd0, 2'd0, 5'd0, 5'd13,5'd0, 0);  // 17 flushed $9 in W
    step(5'd13,1, 5'd0, 0, 5'd0, 0, 0, 0,  0, 2'd3, 2'd0, 5'd0, 5'd0, 5'd13,1);  // 18 $13 from W
    step(5'd0, 0, 5'd0, 0, 5'd15,1, 0, 0,  0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 0);  // 19 add $15
    step(5'd0, 0, 5'd0, 0, 5'd16,1, 0, 0,  0, 2'd0, 2'd0, 5'd15,5'd0, 5'd0, 0);  // 20 add $16
    step(5'd0, 0, 5'd0, 0, 5'd17,1, 0, 0,  0, 2'd0, 2'd0, 5'd16,5'd15,5'd0, 0);  // 21 add $17
    step(5'd17,1, 5'd15,1, 5'd0, 0, 0, 0,  0, 2'd1, 2'd3, 5'd17,5'd16,5'd15,1);  // 22 all slots live

    // Asynchronous reset between edges with every slot live.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    z.idx = 100;
    cmp_all(z);
    #1;
    rst = 1'b0;
    step(5'd17,1, 5'd15,1, 5'd0, 0, 0, 0,  0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 0);  // 23 after reset
    step(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0,  0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 0);  // 24 no stale write

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout reached=1 want=0");
      $fatal(1, "timeout");
    end
  end

endmodule
